// File: rtl/xor_frame_acc.sv
// Frame XOR accumulator: folds masked lane operands of each beat into a running
// XOR and presents one result per frame, with the beat count, over a ready/valid handshake.
module xor_frame_acc #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESETN,
  input  logic [LANES*WIDTH-1:0] I,
  input  logic [LANES-1:0]       I_MASK,
  input  logic                   I_VALID,
  input  logic                   I_LAST,
  output logic                   I_READY,
  output logic [WIDTH-1:0]       O,
  output logic [CNT_W-1:0]       O_BEATS,
  output logic                   O_VALID,
  input  logic                   O_READY
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] acc_r, acc_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             first_r, first_s;
  logic [WIDTH-1:0] o_r, o_s;
  logic [CNT_W-1:0] beats_r, beats_s;

  logic             in_fire_s;
  logic             out_fire_s;
  logic [WIDTH-1:0] beat_s;
  logic [WIDTH-1:0] sum_s;
  logic [CNT_W-1:0] cnt_inc_s;

  function automatic logic [WIDTH-1:0] lane_xor(
    input logic [LANES*WIDTH-1:0] d,
    input logic [LANES-1:0]       m
  );
    logic [WIDTH-1:0] r;
    r = {WIDTH{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      if (m[k]) begin
        r = r ^ d[k*WIDTH +: WIDTH];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + CNT_W'(1);
    end
  endfunction

  assign O_VALID    = (state_r == ST_HOLD);
  assign O          = o_r;
  assign O_BEATS    = beats_r;
  assign I_READY    = !O_VALID || O_READY;
  assign in_fire_s  = I_VALID && I_READY;
  assign out_fire_s = O_VALID && O_READY;

  // Beat reduction and frame-relative running values; a frame's first beat ignores stale acc/cnt.
  always_comb begin
    beat_s = lane_xor(I, I_MASK);
    if (first_r) begin
      sum_s     = beat_s;
      cnt_inc_s = sat_inc({CNT_W{1'b0}});
    end else begin
      sum_s     = acc_r ^ beat_s;
      cnt_inc_s = sat_inc(cnt_r);
    end
  end

  // Next-state and datapath update; an accepted beat in HOLD only happens alongside out_fire.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    first_s = first_r;
    o_s     = o_r;
    beats_s = beats_r;
    case (state_r)
      ST_ACCUM, ST_HOLD: begin
        if (in_fire_s && I_LAST) begin
          o_s     = sum_s;
          beats_s = cnt_inc_s;
          acc_s   = {WIDTH{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          first_s = 1'b1;
          state_s = ST_HOLD;
        end else if (in_fire_s) begin
          acc_s   = sum_s;
          cnt_s   = cnt_inc_s;
          first_s = 1'b0;
          state_s = ST_ACCUM;
        end else if (out_fire_s) begin
          state_s = ST_ACCUM;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_ACCUM;
        first_s = 1'b1;
      end
    endcase
  end

  // State and result registers; reset discards any partial frame.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_r <= ST_ACCUM;
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      first_r <= 1'b1;
      o_r     <= {WIDTH{1'b0}};
      beats_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      first_r <= first_s;
      o_r     <= o_s;
      beats_r <= beats_s;
    end
  end

endmodule

// File: tb/tb_xor_frame_acc.sv
// Directed bench for xor_frame_acc: single-beat vector table plus hand-written
// multi-cycle sequences for backpressure, back-to-back frames, reset and saturation.
module tb_xor_frame_acc;

  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int CNT_W = 8;

  logic                   clk;
  logic                   rst_n;
  logic [LANES*WIDTH-1:0] i_data;
  logic [LANES-1:0]       i_mask;
  logic                   i_valid;
  logic                   i_last;
  logic                   i_ready;
  logic [WIDTH-1:0]       o_data;
  logic [CNT_W-1:0]       o_beats;
  logic                   o_valid;
  logic                   o_ready;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [31:0] lanes;
    logic [3:0]  mask;
    logic [7:0]  exp_o;
  } vec_t;

  vec_t vecs[6];

  xor_frame_acc #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .CLK        (clk),
    .ASYNCRESETN(rst_n),
    .I          (i_data),
    .I_MASK     (i_mask),
    .I_VALID    (i_valid),
    .I_LAST     (i_last),
    .I_READY    (i_ready),
    .O          (o_data),
    .O_BEATS    (o_beats),
    .O_VALID    (o_valid),
    .O_READY    (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] lanes, input logic [3:0] mask, input logic last);
    i_data  = lanes;
    i_mask  = mask;
    i_last  = last;
    i_valid = 1'b1;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = 32'hDEAD_BEEF;
    i_mask  = 4'hF;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{lanes: 32'h0804_0201, mask: 4'b1111, exp_o: 8'h0F};
    vecs[1] = '{lanes: 32'h550F_AAFF, mask: 4'b0101, exp_o: 8'hF0};
    vecs[2] = '{lanes: 32'h1234_5678, mask: 4'b0000, exp_o: 8'h00};
    vecs[3] = '{lanes: 32'hFFFF_FFFF, mask: 4'b1111, exp_o: 8'h00};
    vecs[4] = '{lanes: 32'h7856_3412, mask: 4'b0110, exp_o: 8'h62};
    vecs[5] = '{lanes: 32'hA500_0000, mask: 4'b1000, exp_o: 8'hA5};

    rst_n   = 1'b0;
    o_ready = 1'b1;
    idle();
    #2;
    check("rst_o", 32'(o_data), 32'h00);
    check("rst_beats", 32'(o_beats), 32'h00);
    check("rst_ovalid", 32'(o_valid), 32'h0);
    check("rst_iready", 32'(i_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_iready", 32'(i_ready), 32'h1);

    // Single-beat frames from the table
    for (int v = 0; v < 6; v++) begin
      drive(vecs[v].lanes, vecs[v].mask, 1'b1);
      @(negedge clk);
      idle();
      check($sformatf("vec%0d_o", v), 32'(o_data), 32'(vecs[v].exp_o));
      check($sformatf("vec%0d_beats", v), 32'(o_beats), 32'd1);
      check($sformatf("vec%0d_ovalid", v), 32'(o_valid), 32'h1);
      @(negedge clk);
      check($sformatf("vec%0d_released", v), 32'(o_valid), 32'h0);
    end

    // 3-beat frame under backpressure
    o_ready = 1'b0;
    drive(32'h0000_0011, 4'b0001, 1'b0);
    @(negedge clk);
    check("f3_no_early_valid", 32'(o_valid), 32'h0);
    drive(32'h0000_0022, 4'b0001, 1'b0);
    @(negedge clk);
    drive(32'h0000_0044, 4'b0001, 1'b1);
    @(negedge clk);
    idle();
    for (int c = 0; c < 3; c++) begin
      check("f3_o", 32'(o_data), 32'h77);
      check("f3_beats", 32'(o_beats), 32'd3);
      check("f3_ovalid", 32'(o_valid), 32'h1);
      check("f3_iready_low", 32'(i_ready), 32'h0);
      @(negedge clk);
    end
    o_ready = 1'b1;
    #1;
    check("f3_iready_high", 32'(i_ready), 32'h1);
    @(negedge clk);
    check("f3_accepted", 32'(o_valid), 32'h0);

    // Back-to-back single-beat frames, no bubble
    drive(32'h0000_003C, 4'b0001, 1'b1);
    @(negedge clk);
    check("b2b_first_o", 32'(o_data), 32'h3C);
    check("b2b_first_valid", 32'(o_valid), 32'h1);
    drive(32'h0000_00C3, 4'b0001, 1'b1);
    @(negedge clk);
    idle();
    check("b2b_second_o", 32'(o_data), 32'hC3);
    check("b2b_second_valid", 32'(o_valid), 32'h1);
    check("b2b_second_beats", 32'(o_beats), 32'd1);
    @(negedge clk);
    check("b2b_drain", 32'(o_valid), 32'h0);

    // Reset while a result is held drops O_VALID immediately
    o_ready = 1'b0;
    drive(32'h0000_0099, 4'b0001, 1'b1);
    @(negedge clk);
    idle();
    check("hold_before_rst", 32'(o_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_hold_ovalid", 32'(o_valid), 32'h0);
    check("rst_hold_o", 32'(o_data), 32'h00);
    check("rst_hold_iready", 32'(i_ready), 32'h1);
    #1 rst_n = 1'b1;
    o_ready = 1'b1;
    @(negedge clk);

    // Reset mid-frame discards the partial frame
    drive(32'h0000_0001, 4'b0001, 1'b0);
    @(negedge clk);
    drive(32'h0000_0002, 4'b0001, 1'b0);
    @(negedge clk);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ovalid", 32'(o_valid), 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    drive(32'h0000_005A, 4'b0001, 1'b1);
    @(negedge clk);
    idle();
    check("midrst_o", 32'(o_data), 32'h5A);
    check("midrst_beats", 32'(o_beats), 32'd1);
    check("midrst_valid", 32'(o_valid), 32'h1);
    @(negedge clk);

    // 300-beat frame saturates the beat count
    for (int b = 0; b < 300; b++) begin
      drive(32'h0000_0001, 4'b0001, (b == 299));
      @(negedge clk);
      if (b == 298) begin
        check("sat_no_early_valid", 32'(o_valid), 32'h0);
      end
    end
    idle();
    check("sat_o", 32'(o_data), 32'h00);
    check("sat_beats", 32'(o_beats), 32'd255);
    check("sat_valid", 32'(o_valid), 32'h1);
    @(negedge clk);

    // Idle cycles with garbage on I change nothing
    i_last = 1'b1;
    i_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check("idle_no_valid", 32'(o_valid), 32'h0);
    check("idle_o_kept", 32'(o_data), 32'h00);
    check("idle_beats_kept", 32'(o_beats), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
